// File: rtl/div_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : div_clk_gen
// Brief    : Programmable glitch-free clock divider with boundary-aligned
//            ratio updates, clean stop and sticky illegal-ratio flag.
// Revision : 1.0 - initial release
// ============================================================================
module div_clk_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int MIN_DIV   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_upd_i,
  output logic                 div_clk_o,
  output logic                 div_en_o,
  output logic                 div_tick_o,
  output logic                 cfg_err_o
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_stop = 2'd2;

  localparam logic [DIV_WIDTH-1:0] c_min_div = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] c_one     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] c_zero    = '0;

  logic [1:0]           r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_active;
  logic [DIV_WIDTH-1:0] r_pending;
  logic                 r_pend_vld;
  logic                 r_div_clk;
  logic                 r_div_en;
  logic                 r_div_tick;
  logic                 r_cfg_err;

  logic                 w_cfg_illegal;
  logic [DIV_WIDTH-1:0] w_cfg_div_sat;
  logic [DIV_WIDTH-1:0] w_half;
  logic [DIV_WIDTH-1:0] w_cnt_inc;
  logic                 w_period_end;

  assign w_cfg_illegal = (cfg_div_i < c_min_div);
  assign w_cfg_div_sat = w_cfg_illegal ? c_min_div : cfg_div_i;
  assign w_half        = r_active >> 1;
  assign w_cnt_inc     = r_cnt + c_one;
  assign w_period_end  = (r_cnt == (r_active - c_one));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= c_st_idle;
      r_cnt      <= c_zero;
      r_active   <= c_min_div;
      r_pending  <= c_min_div;
      r_pend_vld <= 1'b0;
      r_div_clk  <= 1'b0;
      r_div_en   <= 1'b0;
      r_div_tick <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (cfg_en_i) begin
            r_state    <= c_st_run;
            if (r_pend_vld) r_active <= r_pending;
            r_pend_vld <= 1'b0;
            r_cnt      <= c_zero;
            r_div_clk  <= 1'b1;
            r_div_en   <= 1'b1;
            r_div_tick <= 1'b1;
          end else begin
            r_div_clk  <= 1'b0;
            r_div_en   <= 1'b0;
            r_div_tick <= 1'b0;
          end
        end

        c_st_run, c_st_stop: begin
          if (w_period_end && (r_state == c_st_stop) && !cfg_en_i) begin
            r_state    <= c_st_idle;
            r_cnt      <= c_zero;
            r_div_clk  <= 1'b0;
            r_div_en   <= 1'b0;
            r_div_tick <= 1'b0;
          end else if (w_period_end) begin
            // New period: only here may a pending ratio become active.
            r_state    <= cfg_en_i ? c_st_run : c_st_stop;
            r_cnt      <= c_zero;
            if (r_pend_vld) r_active <= r_pending;
            r_pend_vld <= 1'b0;
            r_div_clk  <= 1'b1;
            r_div_tick <= 1'b1;
          end else begin
            r_state    <= cfg_en_i ? c_st_run : c_st_stop;
            r_cnt      <= w_cnt_inc;
            r_div_clk  <= (w_cnt_inc < w_half);
            r_div_tick <= 1'b0;
          end
        end

        default: begin
          r_state    <= c_st_idle;
          r_cnt      <= c_zero;
          r_div_clk  <= 1'b0;
          r_div_en   <= 1'b0;
          r_div_tick <= 1'b0;
        end
      endcase

      // Placed last so a strobe on a boundary edge re-arms pend_vld.
      if (cfg_upd_i) begin
        r_pending  <= w_cfg_div_sat;
        r_pend_vld <= 1'b1;
        if (w_cfg_illegal) r_cfg_err <= 1'b1;
      end
    end
  end

  assign div_clk_o  = r_div_clk;
  assign div_en_o   = r_div_en;
  assign div_tick_o = r_div_tick;
  assign cfg_err_o  = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/div_clk_gen.md
Name: div_clk_gen

Overview:
- Programmable clock-divider core that produces the divided clock and divider-enable status at the divider top level (`div_clk_o`, `div_en_o`).
- Sits directly downstream of the register block. It consumes the enable bit and the divide-ratio field that the command interface (UART/SPI/reg) writes.
- Generates a registered, glitch-free divided clock with controlled ratio updates and clean stop.

Parameters:
- DIV_WIDTH, 8, width of the divide-ratio field.
- MIN_DIV, 2, smallest legal ratio. Any programmed value below it is replaced by MIN_DIV.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- cfg_en_i  input  1  divider enable level from the register block.
- cfg_div_i  input  DIV_WIDTH  requested divide ratio N.
- cfg_upd_i  input  1  one-cycle strobe; cfg_div_i is valid and must be captured.
- div_clk_o  output  1  divided clock, registered.
- div_en_o  output  1  high while the divider is generating periods.
- div_tick_o  output  1  one-cycle pulse on the first cycle of every period.
- cfg_err_o  output  1  sticky flag: an illegal ratio (< MIN_DIV) was captured.

Behaviour:
- Reset (rst_i=1, asynchronous): state=IDLE; cnt=0; active ratio=MIN_DIV; pending ratio=MIN_DIV; pend_vld=0; div_clk_o=0; div_en_o=0; div_tick_o=0; cfg_err_o=0. Outputs clear immediately, not at the next edge.
- Ratio capture (any state): when cfg_upd_i=1, pending <= max(cfg_div_i, MIN_DIV) and pend_vld <= 1.
  - If cfg_div_i < MIN_DIV, cfg_err_o <= 1. It stays set until reset.
  - Back-to-back strobes: the last one wins.
- Phase split for ratio N: H = floor(N/2) high cycles, then N-H low cycles.
  - N=2: 1 high / 1 low.
  - N=5: 2 high / 3 low.
  - Max N = 2^DIV_WIDTH-1.
- IDLE:
  - div_clk_o=0, div_en_o=0.
  - On an edge with cfg_en_i=1, go to RUN and in that same edge:
    - active <= (pend_vld ? pending : active); pend_vld <= 0
    - cnt <= 0
    - div_clk_o <= 1, div_en_o <= 1, div_tick_o <= 1
  - Latency from cfg_en_i sampled high to div_clk_o high: 1 edge.
- RUN, each edge:
  - If cnt == active-1 (period end):
    - cnt <= 0
    - if pend_vld, active <= pending and pend_vld <= 0
    - div_tick_o <= 1, div_clk_o <= 1
  - Otherwise:
    - cnt <= cnt+1
    - div_tick_o <= 0
    - div_clk_o <= (cnt+1 < H)
  - If cfg_en_i=0 on this edge, go to STOP, and the counter update above still occurs.
- Ratio changes take effect only at a period boundary. A period already started always completes with its original ratio. There are never truncated or runt pulses.
- STOP:
  - Finishes the current period with normal counting.
  - At period end with cfg_en_i=0: go to IDLE; div_clk_o <= 0; div_en_o <= 0; div_tick_o <= 0; cnt <= 0.
  - At period end with cfg_en_i=1: behave exactly as a RUN period end and return to RUN. There is no gap.
  - If cfg_en_i returns to 1 mid-period: go to RUN with no change to cnt or outputs.
- Enable dropping in the last cycle of a period: STOP is entered with cnt=0 of a fresh period. That full period completes before IDLE.
- cfg_upd_i coinciding with a period end: the old pending value is applied, and the new value becomes pending for the next boundary.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

Test Plan:
- Reset, then cfg_div_i=4 with cfg_upd_i pulse, then cfg_en_i=1 -> div_clk_o high 1 edge later; pattern 1,1,0,0 repeating; div_tick_o every 4 cycles, aligned with each rising div_clk_o; div_en_o=1.
- cfg_div_i=5 -> per period 2 high, 3 low, tick every 5 cycles. cfg_div_i=255 -> 127 high, 128 low.
- cfg_div_i=0, then 1 (each with upd) -> both run as N=2 (1 high/1 low); cfg_err_o=1 and stays 1 after a later legal update to 6; only rst_i clears it.
- Running N=4, update to 6 at cnt=1 -> current period finishes as 2 high/2 low; next period 3 high/3 low; no runt pulse.
- Running N=6, cfg_en_i=0 during the 2nd high cycle -> period completes (3 high, 3 low), then div_en_o=0 and div_clk_o=0 at the boundary edge. Re-enable during the low phase -> next period starts immediately with no idle cycle.
- rst_i asserted mid-high phase, asynchronous to clk_i -> div_clk_o, div_en_o and div_tick_o drop before the next edge. After release, the block stays IDLE until cfg_en_i=1 and uses ratio 2 unless a new update arrives.
